// File: rtl/sb_queue_mp.sv
// sb_queue_mp: in-order tracking queue for a multi-issue pipeline.
// Allocates up to ISSUE_W IDs per cycle, collects out-of-order results on
// WB_PORTS writeback ports and retires completed entries in program order
// on up to COMMIT_W commit lanes. An exception entry retires alone as the
// last lane of its commit group.
// Optional feature: define SB_QUEUE_MP_WB_BYPASS_EN to let a writeback that
// hits a head-window entry count as done for commit in the same cycle.
module sb_queue_mp #(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned ISSUE_W    = 2,
  parameter int unsigned WB_PORTS   = 4,
  parameter int unsigned COMMIT_W   = 2,
  parameter int unsigned PAYLOAD_W  = 64,
  parameter int unsigned DATA_W     = 64,
  localparam int unsigned ID_W      = $clog2(NR_ENTRIES)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  // allocation from decode
  input  logic [ISSUE_W-1:0]                   alloc_valid_i,
  input  logic [ISSUE_W-1:0][PAYLOAD_W-1:0]    alloc_payload_i,
  output logic [ISSUE_W-1:0]                   alloc_ready_o,
  output logic [ISSUE_W-1:0][ID_W-1:0]         alloc_id_o,
  // writeback ports
  input  logic [WB_PORTS-1:0]                  wb_valid_i,
  input  logic [WB_PORTS-1:0][ID_W-1:0]        wb_id_i,
  input  logic [WB_PORTS-1:0][DATA_W-1:0]      wb_data_i,
  input  logic [WB_PORTS-1:0]                  wb_ex_i,
  // commit lanes
  output logic [COMMIT_W-1:0]                  commit_valid_o,
  output logic [COMMIT_W-1:0][PAYLOAD_W-1:0]   commit_payload_o,
  output logic [COMMIT_W-1:0][DATA_W-1:0]      commit_data_o,
  output logic [COMMIT_W-1:0]                  commit_ex_o,
  output logic [COMMIT_W-1:0][ID_W-1:0]        commit_id_o,
  input  logic [COMMIT_W-1:0]                  commit_ack_i,
  // occupancy
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [ID_W:0]                        count_o
);

  localparam logic [ID_W:0] ONE   = (ID_W+1)'(1);
  localparam logic [ID_W:0] DEPTH = (ID_W+1)'(NR_ENTRIES);

  // Per-entry state
  logic [NR_ENTRIES-1:0] valid_q;
  logic [NR_ENTRIES-1:0] done_q;
  logic [NR_ENTRIES-1:0] ex_q;
  logic [PAYLOAD_W-1:0]  payload_q [NR_ENTRIES];
  logic [DATA_W-1:0]     data_q    [NR_ENTRIES];

  // Pointers and occupancy; count separates full from empty when head == tail
  logic [ID_W-1:0] head_q;
  logic [ID_W-1:0] tail_q;
  logic [ID_W:0]   count_q;

  // Writeback resolution per entry
  logic [NR_ENTRIES-1:0] wb_hit;
  logic [NR_ENTRIES-1:0] wb_apply;
  logic [NR_ENTRIES-1:0] wb_ex_sel;
  logic [DATA_W-1:0]     wb_data_sel [NR_ENTRIES];

  // Allocation
  logic [ID_W:0]         free_slots;
  logic [ISSUE_W-1:0]    alloc_acc;
  logic [NR_ENTRIES-1:0] alloc_set;
  logic [ID_W:0]         n_acc;

  // Retirement
  logic [COMMIT_W-1:0]   retire;
  logic [NR_ENTRIES-1:0] retire_clr;
  logic [ID_W:0]         n_ret;

  assign count_o    = count_q;
  assign full_o     = (count_q == DEPTH);
  assign empty_o    = (count_q == '0);
  assign free_slots = DEPTH - count_q;

  // Resolve writeback ports onto entries; the lowest port index wins a collision
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    wb_hit    = '0;
    wb_ex_sel = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      wb_data_sel[i] = '0;
      for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && (wb_id_i[p] == ID_W'(i))) begin
          wb_hit[i]      = 1'b1;
          wb_data_sel[i] = wb_data_i[p];
          wb_ex_sel[i]   = wb_ex_i[p];
        end
      end
    end
    // Only live, not-yet-completed entries accept a result
    wb_apply = wb_hit & valid_q & ~done_q;
  end

  // Allocation lanes: ready from registered count, acceptance as a strict prefix
  always_comb begin
    logic chain;
    chain     = 1'b1;
    n_acc     = '0;
    alloc_acc = '0;
    alloc_set = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      alloc_ready_o[k] = (int'(free_slots) > k);
      alloc_id_o[k]    = tail_q + ID_W'(k);
      alloc_acc[k]     = chain & alloc_valid_i[k] & alloc_ready_o[k];
      chain            = alloc_acc[k];
      if (alloc_acc[k]) begin
        alloc_set[alloc_id_o[k]] = 1'b1;
        n_acc                    = n_acc + ONE;
      end
    end
  end

  // Commit window from head: in-order done prefix, cut after an exception entry
  always_comb begin
    logic            chain;
    logic            ret_chain;
    logic            lane_ok;
    logic [ID_W-1:0] idx;
    logic            eff_done;
    logic            eff_ex;
    logic [DATA_W-1:0] eff_data;
    chain            = 1'b1;
    ret_chain        = 1'b1;
    n_ret            = '0;
    retire           = '0;
    retire_clr       = '0;
    commit_valid_o   = '0;
    commit_payload_o = '0;
    commit_data_o    = '0;
    commit_ex_o      = '0;
    commit_id_o      = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      idx      = head_q + ID_W'(k);
      eff_done = done_q[idx];
      eff_ex   = ex_q[idx];
      eff_data = data_q[idx];
`ifdef SB_QUEUE_MP_WB_BYPASS_EN
      if (wb_apply[idx]) begin
        eff_done = 1'b1;
        eff_ex   = wb_ex_sel[idx];
        eff_data = wb_data_sel[idx];
      end
`endif
      lane_ok = chain & valid_q[idx] & eff_done & (int'(count_q) > k);
      chain   = lane_ok & ~eff_ex;
      commit_valid_o[k] = lane_ok;
      if (lane_ok) begin
        commit_payload_o[k] = payload_q[idx];
        commit_data_o[k]    = eff_data;
        commit_ex_o[k]      = eff_ex;
        commit_id_o[k]      = idx;
      end
      retire[k] = ret_chain & commit_ack_i[k] & lane_ok;
      ret_chain = retire[k];
      if (retire[k]) begin
        retire_clr[idx] = 1'b1;
        n_ret           = n_ret + ONE;
      end
    end
  end

  // Control state: flags, pointers and count; flush overrides all traffic
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      valid_q <= '0;
      done_q  <= '0;
      ex_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      done_q  <= '0;
      ex_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= (valid_q & ~retire_clr) | alloc_set;
      done_q  <= (done_q | wb_apply) & ~retire_clr & ~alloc_set;
      ex_q    <= ((ex_q & ~wb_apply) | (wb_ex_sel & wb_apply)) & ~alloc_set;
      head_q  <= head_q + n_ret[ID_W-1:0];
      tail_q  <= tail_q + n_acc[ID_W-1:0];
      count_q <= count_q + n_acc - n_ret;
    end
  end

  // Payload and result storage; contents are only observed behind valid/done
  always_ff @(posedge clk_i) begin
    // NOTE: the storage arrays are deliberately not reset; valid gating hides stale contents.
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (wb_apply[i]) data_q[i] <= wb_data_sel[i];
    end
    for (int k = 0; k < ISSUE_W; k++) begin
      if (alloc_acc[k]) payload_q[alloc_id_o[k]] <= alloc_payload_i[k];
    end
  end

endmodule

// File: tb/tb_sb_queue_mp.sv
// Directed self-checking bench for sb_queue_mp with default parameters
// (8 entries, 2 issue lanes, 4 writeback ports, 2 commit lanes), built
// without the writeback bypass.
module tb_sb_queue_mp;

  localparam int NR_ENTRIES = 8;
  localparam int ISSUE_W    = 2;
  localparam int WB_PORTS   = 4;
  localparam int COMMIT_W   = 2;
  localparam int PAYLOAD_W  = 64;
  localparam int DATA_W     = 64;
  localparam int ID_W       = 3;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  logic [ISSUE_W-1:0]                 alloc_valid_i;
  logic [ISSUE_W-1:0][PAYLOAD_W-1:0]  alloc_payload_i;
  logic [ISSUE_W-1:0]                 alloc_ready_o;
  logic [ISSUE_W-1:0][ID_W-1:0]       alloc_id_o;
  logic [WB_PORTS-1:0]                wb_valid_i;
  logic [WB_PORTS-1:0][ID_W-1:0]      wb_id_i;
  logic [WB_PORTS-1:0][DATA_W-1:0]    wb_data_i;
  logic [WB_PORTS-1:0]                wb_ex_i;
  logic [COMMIT_W-1:0]                commit_valid_o;
  logic [COMMIT_W-1:0][PAYLOAD_W-1:0] commit_payload_o;
  logic [COMMIT_W-1:0][DATA_W-1:0]    commit_data_o;
  logic [COMMIT_W-1:0]                commit_ex_o;
  logic [COMMIT_W-1:0][ID_W-1:0]      commit_id_o;
  logic [COMMIT_W-1:0]                commit_ack_i;
  logic                               full_o;
  logic                               empty_o;
  logic [ID_W:0]                      count_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  sb_queue_mp #(
    .NR_ENTRIES(NR_ENTRIES), .ISSUE_W(ISSUE_W), .WB_PORTS(WB_PORTS),
    .COMMIT_W(COMMIT_W), .PAYLOAD_W(PAYLOAD_W), .DATA_W(DATA_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .alloc_valid_i   (alloc_valid_i),
    .alloc_payload_i (alloc_payload_i),
    .alloc_ready_o   (alloc_ready_o),
    .alloc_id_o      (alloc_id_o),
    .wb_valid_i      (wb_valid_i),
    .wb_id_i         (wb_id_i),
    .wb_data_i       (wb_data_i),
    .wb_ex_i         (wb_ex_i),
    .commit_valid_o  (commit_valid_o),
    .commit_payload_o(commit_payload_o),
    .commit_data_o   (commit_data_o),
    .commit_ex_o     (commit_ex_o),
    .commit_id_o     (commit_id_o),
    .commit_ack_i    (commit_ack_i),
    .full_o          (full_o),
    .empty_o         (empty_o),
    .count_o         (count_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    flush_i         = 1'b0;
    alloc_valid_i   = '0;
    alloc_payload_i = '0;
    wb_valid_i      = '0;
    wb_id_i         = '0;
    wb_data_i       = '0;
    wb_ex_i         = '0;
    commit_ack_i    = '0;
  endtask

  // Advance one clock, then settle and drop all one-shot inputs
  task automatic tick();
    @(posedge clk_i);
    #1;
    clear_inputs();
  endtask

  task automatic wb(input int p, input int id, input logic [63:0] data, input logic ex);
    wb_valid_i[p] = 1'b1;
    wb_id_i[p]    = ID_W'(id);
    wb_data_i[p]  = data;
    wb_ex_i[p]    = ex;
  endtask

  // Present two allocation lanes with payload 0x100 + expected ID
  task automatic alloc2(input int id0);
    alloc_valid_i      = 2'b11;
    alloc_payload_i[0] = 64'h100 + 64'(id0 % NR_ENTRIES);
    alloc_payload_i[1] = 64'h100 + 64'((id0 + 1) % NR_ENTRIES);
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    #1;
    // Reset state
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_cvalid", 64'(commit_valid_o), 64'd0);
    check("rst_ready", 64'(alloc_ready_o), 64'b11);
    check("rst_id0", 64'(alloc_id_o[0]), 64'd0);
    check("rst_id1", 64'(alloc_id_o[1]), 64'd1);
    check("rst_cpay", 64'(commit_payload_o[0]), 64'd0);
    check("rst_cid", 64'(commit_id_o[1]), 64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Non-prefix valid on empty queue is not accepted
    alloc_valid_i = 2'b10;
    tick();
    check("np_count", 64'(count_o), 64'd0);
    check("np_id0", 64'(alloc_id_o[0]), 64'd0);

    // Fill: IDs 0..7 over four cycles
    for (int c = 0; c < 4; c++) begin
      check("fill_ready", 64'(alloc_ready_o), 64'b11);
      check("fill_id0", 64'(alloc_id_o[0]), 64'(2 * c));
      check("fill_id1", 64'(alloc_id_o[1]), 64'(2 * c + 1));
      alloc2(2 * c);
      tick();
    end
    check("full_full", 64'(full_o), 64'd1);
    check("full_ready", 64'(alloc_ready_o), 64'b00);
    check("full_count", 64'(count_o), 64'd8);

    // Full queue with simultaneous commit: freed slot not reusable this cycle
    wb(0, 0, 64'h55, 1'b0);
    tick();
    check("fullc_cvalid", 64'(commit_valid_o), 64'b01);
    check("fullc_data", commit_data_o[0], 64'h55);
    check("fullc_pay", commit_payload_o[0], 64'h100);
    commit_ack_i  = 2'b01;
    alloc2(0);
    check("fullc_ready_same", 64'(alloc_ready_o), 64'b00);
    tick();
    check("fullc_count", 64'(count_o), 64'd7);
    check("fullc_ready_next", 64'(alloc_ready_o), 64'b01);
    check("fullc_notfull", 64'(full_o), 64'd0);
    flush_i = 1'b1;
    tick();
    check("flush1_count", 64'(count_o), 64'd0);

    // Out-of-order writeback 3,2,1,0; commit waits for ID0
    alloc2(0);
    tick();
    alloc2(2);
    tick();
    check("ooo_count", 64'(count_o), 64'd4);
    wb(0, 3, 64'h33, 1'b0);
    tick();
    check("ooo_cv3", 64'(commit_valid_o), 64'b00);
    wb(1, 2, 64'h32, 1'b0);
    tick();
    check("ooo_cv2", 64'(commit_valid_o), 64'b00);
    wb(2, 1, 64'h31, 1'b0);
    tick();
    check("ooo_cv1", 64'(commit_valid_o), 64'b00);
    wb(3, 0, 64'h30, 1'b0);
    check("ooo_cv0_same", 64'(commit_valid_o), 64'b00);
    tick();
    check("ooo_cv01", 64'(commit_valid_o), 64'b11);
    check("ooo_id0", 64'(commit_id_o[0]), 64'd0);
    check("ooo_id1", 64'(commit_id_o[1]), 64'd1);
    check("ooo_data0", commit_data_o[0], 64'h30);
    check("ooo_pay1", commit_payload_o[1], 64'h101);
    commit_ack_i = 2'b11;
    tick();
    check("ooo_cv23", 64'(commit_valid_o), 64'b11);
    check("ooo_id2", 64'(commit_id_o[0]), 64'd2);
    check("ooo_id3", 64'(commit_id_o[1]), 64'd3);
    check("ooo_data3", commit_data_o[1], 64'h33);
    check("ooo_count2", 64'(count_o), 64'd2);
    commit_ack_i = 2'b11;
    tick();
    check("ooo_empty", 64'(empty_o), 64'd1);
    flush_i = 1'b1;
    tick();

    // Exception narrows the commit group
    alloc2(0);
    tick();
    wb(0, 0, 64'hE0, 1'b1);
    wb(1, 1, 64'h11, 1'b0);
    tick();
    check("ex_cvalid", 64'(commit_valid_o), 64'b01);
    check("ex_ex0", 64'(commit_ex_o[0]), 64'd1);
    check("ex_data0", commit_data_o[0], 64'hE0);
    commit_ack_i = 2'b11;
    tick();
    check("ex_count", 64'(count_o), 64'd1);
    check("ex_cvalid2", 64'(commit_valid_o), 64'b01);
    check("ex_id1", 64'(commit_id_o[0]), 64'd1);
    check("ex_ex1", 64'(commit_ex_o[0]), 64'd0);
    check("ex_data1", commit_data_o[0], 64'h11);
    commit_ack_i = 2'b01;
    tick();
    check("ex_empty", 64'(empty_o), 64'd1);

    // Port collision on ID5 and a writeback to unallocated ID7
    alloc2(2);
    tick();
    alloc2(4);
    tick();
    wb(0, 5, 64'hA, 1'b0);
    wb(2, 5, 64'hB, 1'b0);
    wb(1, 7, 64'hC, 1'b0);
    wb(3, 2, 64'h22, 1'b0);
    tick();
    check("col_cv", 64'(commit_valid_o), 64'b01);
    check("col_id2", 64'(commit_id_o[0]), 64'd2);
    wb(0, 3, 64'h23, 1'b0);
    wb(1, 4, 64'h24, 1'b0);
    tick();
    check("col_cv23", 64'(commit_valid_o), 64'b11);
    commit_ack_i = 2'b11;
    tick();
    check("col_cv45", 64'(commit_valid_o), 64'b11);
    check("col_id5", 64'(commit_id_o[1]), 64'd5);
    check("col_data5", commit_data_o[1], 64'hA);
    check("col_pay4", commit_payload_o[0], 64'h104);
    commit_ack_i = 2'b11;
    tick();
    check("col_empty", 64'(count_o), 64'd0);

    // Wrap-around allocation 6,7,0,1; ID7 must not carry the stale writeback
    check("wrap_id6", 64'(alloc_id_o[0]), 64'd6);
    check("wrap_id7", 64'(alloc_id_o[1]), 64'd7);
    alloc2(6);
    tick();
    check("wrap_id0", 64'(alloc_id_o[0]), 64'd0);
    check("wrap_id1", 64'(alloc_id_o[1]), 64'd1);
    alloc2(0);
    tick();
    check("wrap_count", 64'(count_o), 64'd4);
    wb(0, 6, 64'h66, 1'b0);
    tick();
    check("wrap_cv", 64'(commit_valid_o), 64'b01);
    check("wrap_cid", 64'(commit_id_o[0]), 64'd6);
    // Flush overrides simultaneous allocation and ack
    flush_i      = 1'b1;
    alloc2(2);
    commit_ack_i = 2'b01;
    tick();
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_empty", 64'(empty_o), 64'd1);
    check("flush_cv", 64'(commit_valid_o), 64'b00);
    check("flush_id0", 64'(alloc_id_o[0]), 64'd0);

    // Asynchronous reset mid-operation
    alloc2(0);
    tick();
    check("ar_count_pre", 64'(count_o), 64'd2);
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_count", 64'(count_o), 64'd0);
    check("ar_empty", 64'(empty_o), 64'd1);
    check("ar_id1", 64'(alloc_id_o[1]), 64'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
